// File: rtl/mult_pkg.sv
// Shared widths, multiplier state encodings and scheduler states used by the
// multiplier-sharing scheduler and its benches.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        MS_IDLE      = 3'b000,
        MS_LSB       = 3'b001,
        MS_MID       = 3'b010,
        MS_MSB       = 3'b011,
        MS_CALC_DONE = 3'b100,
        MS_ERR       = 3'b101
    } mult_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECOVER,
        S_RESP
    } sched_state_e;

endpackage

// File: rtl/mult_share_sched_if.sv
// Two request channels and one shared tagged response channel of the
// multiplier-sharing scheduler.
interface mult_share_sched_if;
    import mult_pkg::*;

    logic              req0_valid;
    logic [OP_W-1:0]   req0_a;
    logic [OP_W-1:0]   req0_b;
    logic              req0_ready;
    logic              req1_valid;
    logic [OP_W-1:0]   req1_a;
    logic [OP_W-1:0]   req1_b;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [PROD_W-1:0] rsp_product;
    logic              rsp_err;

    // master: requesters plus response consumer; slave: the scheduler
    modport master (
        output req0_valid, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_a, req1_b, input req1_ready,
        input  rsp_valid, rsp_id, rsp_product, rsp_err, output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_a, req1_b, output req1_ready,
        output rsp_valid, rsp_id, rsp_product, rsp_err, input rsp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins
// a tie. Purely combinational, one-hot grant.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] |  last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/mult_share_sched.sv
// Shares one sequential 8x8 multiplier between two requesters: arbitrates,
// issues, waits for done/error/timeout, and returns a tagged product.
module mult_share_sched
    import mult_pkg::*;
#(
    parameter int         TIMEOUT  = 16,
    parameter logic [2:0] ERR_CODE = 3'b101
) (
    input  logic              clk,
    input  logic              reset_a,
    mult_share_sched_if.slave bus,
    output logic              mult_start,
    output logic [OP_W-1:0]   mult_a,
    output logic [OP_W-1:0]   mult_b,
    input  logic              mult_done,
    input  logic [PROD_W-1:0] mult_product,
    input  logic [2:0]        mult_state,
    output logic              mult_rst_n,
    output logic              busy
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    sched_state_e  state;
    logic          last_grant;
    logic          id_q;
    logic [TW-1:0] timer;
    logic [1:0]    grant;
    logic          in_idle;

    rr_arb2 u_arb (
        .valid      ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign in_idle        = (state == S_IDLE);
    assign bus.req0_ready = in_idle & grant[0];
    assign bus.req1_ready = in_idle & grant[1];
    assign busy           = ~in_idle;
    // Multiplier is held in reset with us, and pulsed for one cycle on failure.
    assign mult_rst_n     = ~(reset_a | (state == S_RECOVER));

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state           <= S_IDLE;
            last_grant      <= 1'b1;
            id_q            <= 1'b0;
            timer           <= '0;
            mult_start      <= 1'b0;
            mult_a          <= '0;
            mult_b          <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != 2'b00) begin
                        mult_a     <= grant[1] ? bus.req1_a : bus.req0_a;
                        mult_b     <= grant[1] ? bus.req1_b : bus.req0_b;
                        id_q       <= grant[1];
                        mult_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mult_start <= 1'b0;
                    timer      <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // Error and timeout take priority over a coincident done.
                    if (mult_state == ERR_CODE || timer == TIMER_LAST) begin
                        bus.rsp_id      <= id_q;
                        bus.rsp_product <= '0;
                        bus.rsp_err     <= 1'b1;
                        state           <= S_RECOVER;
                    end else if (mult_done) begin
                        bus.rsp_id      <= id_q;
                        bus.rsp_product <= mult_product;
                        bus.rsp_err     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= S_RESP;
                    end
                end
                S_RECOVER: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        last_grant    <= bus.rsp_id;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural multiplier stub
// whose latency, completion and error reporting are steered by each test.
module tb_mult_share_sched;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        mult_start;
    logic [7:0]  mult_a, mult_b;
    logic        mult_done = 1'b0;
    logic [15:0] mult_product = '0;
    logic [2:0]  mult_state = 3'b000;
    logic        mult_rst_n;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stub_cnt = -1;
    int stub_lat = 5;
    bit stub_done_en = 1'b1;
    int rst_lo_cnt = 0;

    mult_share_sched_if bus ();

    mult_share_sched #(.TIMEOUT(16), .ERR_CODE(3'b101)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .bus          (bus),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .mult_state   (mult_state),
        .mult_rst_n   (mult_rst_n),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier stub: done pulses stub_lat cycles after the start cycle.
    always @(negedge clk) begin
        if (reset_a || !mult_rst_n) begin
            if (!reset_a) rst_lo_cnt++;
            stub_cnt  = -1;
            mult_done = 1'b0;
        end else begin
            mult_done = 1'b0;
            if (mult_start) begin
                stub_cnt = stub_lat;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && stub_done_en) begin
                    mult_done    = 1'b1;
                    mult_product = {8'd0, mult_a} * {8'd0, mult_b};
                end
            end
        end
    end

    task automatic wait_rsp(input int max_cycles);
        for (int i = 0; i < max_cycles && bus.rsp_valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic wait_grant(input int max_cycles);
        for (int i = 0; i < max_cycles && !(bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1); i++)
            @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, mult_start, bus.rsp_valid, mult_rst_n, bus.req0_ready, bus.req1_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b start=%b rsp_valid=%b rst_n=%b rdy=%b%b want all 0",
                     busy, mult_start, bus.rsp_valid, mult_rst_n, bus.req1_ready, bus.req0_ready);
        end
        checks++;
        if ({mult_a, mult_b, bus.rsp_product, bus.rsp_id, bus.rsp_err} !== 34'd0) begin
            failures++;
            $display("FAIL reset_data: a=%h b=%h prod=%h id=%b err=%b want all 0",
                     mult_a, mult_b, bus.rsp_product, bus.rsp_id, bus.rsp_err);
        end
        reset_a = 1'b0;
        #1;
        checks++;
        if (mult_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rst_n: got %b want 1", mult_rst_n);
        end
    endtask

    task automatic test_single();
        int t0;
        @(negedge clk);
        bus.req0_a = 8'd12; bus.req0_b = 8'd13; bus.req0_valid = 1'b1;
        #1;
        t0 = cyc;
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready);
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        checks++;
        if (mult_start !== 1'b1 || busy !== 1'b1 || mult_a !== 8'd12 || mult_b !== 8'd13) begin
            failures++;
            $display("FAIL single_issue: start=%b busy=%b a=%0d b=%0d want 1 1 12 13",
                     mult_start, busy, mult_a, mult_b);
        end
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b0) begin
            failures++;
            $display("FAIL single_start_pulse: got %b want 0", mult_start);
        end
        wait_rsp(40);
        checks++;
        if (bus.rsp_valid !== 1'b1 || cyc - t0 != 7) begin
            failures++;
            $display("FAIL single_latency: valid=%b cycles=%0d want 1 and 7", bus.rsp_valid, cyc - t0);
        end
        checks++;
        if (bus.rsp_id !== 1'b0 || bus.rsp_product !== 16'd156 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL single_rsp: id=%b prod=%0d err=%b want 0 156 0",
                     bus.rsp_id, bus.rsp_product, bus.rsp_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b rsp_valid=%b want 0 0", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        bit [2:0]    exp_ids = 3'b010;
        logic [15:0] exp_p;
        logic        got;
        do_reset();
        bus.req0_a = 8'd255; bus.req0_b = 8'd255;
        bus.req1_a = 8'd3;   bus.req1_b = 8'd7;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_p = (k == 1) ? 16'd21 : 16'hFE01;
            wait_grant(40);
            got = bus.req1_ready;
            checks++;
            if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || got !== exp_ids[k]) begin
                failures++;
                $display("FAIL contention_grant%0d: r0=%b r1=%b want id %0d", k,
                         bus.req0_ready, bus.req1_ready, exp_ids[k]);
            end
            @(negedge clk);
            if (k == 2) begin
                bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
            end
            wait_rsp(40);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_ids[k] || bus.rsp_product !== exp_p
                || bus.rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL contention_rsp%0d: valid=%b id=%b prod=%h err=%b want 1 %0d %h 0", k,
                         bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err, exp_ids[k], exp_p);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        bus.req1_a = 8'd5; bus.req1_b = 8'd6; bus.req1_valid = 1'b1;
        #1;
        wait_grant(40);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp(40);
        bus.req0_a = 8'd9; bus.req0_b = 8'd9; bus.req0_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_product !== 16'd30
                || bus.rsp_err !== 1'b0 || busy !== 1'b1 || bus.req0_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold%0d: valid=%b id=%b prod=%0d err=%b busy=%b r0=%b want 1 1 30 0 1 0",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err, busy, bus.req0_ready);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: busy=%b valid=%b r0=%b want 0 0 1",
                     busy, bus.rsp_valid, bus.req0_ready);
        end
        bus.req0_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_error();
        stub_lat = 10;
        bus.req0_a = 8'd2; bus.req0_b = 8'd3; bus.req0_valid = 1'b1;
        #1;
        wait_grant(40);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        mult_state = 3'b101;
        @(negedge clk);
        mult_state = 3'b000;
        checks++;
        if (mult_rst_n !== 1'b0 || busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL error_recover: rst_n=%b busy=%b valid=%b want 0 1 0", mult_rst_n, busy, bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (mult_rst_n !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL error_resp_timing: rst_n=%b valid=%b want 1 1", mult_rst_n, bus.rsp_valid);
        end
        checks++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_product !== 16'd0 || bus.rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL error_rsp: err=%b prod=%h id=%b want 1 0000 0", bus.rsp_err, bus.rsp_product, bus.rsp_id);
        end
        @(negedge clk);
        stub_lat = 5;
    endtask

    task automatic test_timeout();
        int t0;
        stub_done_en = 1'b0;
        bus.req1_a = 8'd7; bus.req1_b = 8'd7; bus.req1_valid = 1'b1;
        #1;
        wait_grant(40);
        t0 = cyc;
        rst_lo_cnt = 0;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp(40);
        checks++;
        if (bus.rsp_valid !== 1'b1 || cyc - t0 != 19) begin
            failures++;
            $display("FAIL timeout_latency: valid=%b cycles=%0d want 1 and 19", bus.rsp_valid, cyc - t0);
        end
        checks++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_product !== 16'd0 || bus.rsp_id !== 1'b1) begin
            failures++;
            $display("FAIL timeout_rsp: err=%b prod=%h id=%b want 1 0000 1", bus.rsp_err, bus.rsp_product, bus.rsp_id);
        end
        checks++;
        if (rst_lo_cnt != 1) begin
            failures++;
            $display("FAIL timeout_mult_reset: reset cycles=%0d want 1", rst_lo_cnt);
        end
        @(negedge clk);
        stub_done_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int seen;
        stub_done_en = 1'b0;
        bus.req0_a = 8'd4; bus.req0_b = 8'd4; bus.req0_valid = 1'b1;
        #1;
        wait_grant(40);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        #1;
        checks++;
        if (mult_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_rst_n: got %b want 0", mult_rst_n);
        end
        @(negedge clk);
        checks++;
        if ({busy, mult_start, bus.rsp_valid, bus.rsp_err, bus.rsp_id, mult_a, mult_b, bus.rsp_product} !== 37'd0) begin
            failures++;
            $display("FAIL resetmid_outputs: busy=%b start=%b valid=%b a=%h b=%h prod=%h want all 0",
                     busy, mult_start, bus.rsp_valid, mult_a, mult_b, bus.rsp_product);
        end
        reset_a = 1'b0;
        stub_done_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL resetmid_no_rsp: rsp_valid cycles=%0d want 0", seen);
        end
        bus.req1_a = 8'd10; bus.req1_b = 8'd20; bus.req1_valid = 1'b1;
        #1;
        checks++;
        if (bus.req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL resetmid_accept: r1=%b want 1", bus.req1_ready);
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        wait_rsp(40);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_product !== 16'd200 || bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_rsp: valid=%b id=%b prod=%0d err=%b want 1 1 200 0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.rsp_err);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Sequencing scheduler that shares the single 8x8 sequential multiplier (multiplier controller plus 4x4 datapath) between two requesters. It arbitrates round-robin between the requesters, latches the winner's operands, and pulses the multiplier start. It then waits for done, error or timeout, and returns a tagged 16-bit product on one shared response channel with valid/ready handshake. It sits between the requester logic and the multiplier top level and owns the multiplier's start and reset.

## Interface
Parameters:
- TIMEOUT, 16: max cycles in WAIT before the operation is declared failed; legal range 8..255.
- ERR_CODE, 3'b101: multiplier state_out value that denotes the error state.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_a  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request pending; must hold, with operands stable, until ready.
- req0_a, req0_b / req1_a, req1_b  in  8  unsigned operands.
- req0_ready / req1_ready  out  1  request accepted this cycle; combinational; at most one high.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of the response.
- rsp_product  out  16  unsigned product; 0 when rsp_err.
- rsp_err  out  1  operation failed (multiplier error or timeout).
- mult_start  out  1  to multiplier start.
- mult_a, mult_b  out  8  operands to multiplier datapath; held stable from ISSUE until response.
- mult_done  in  1  multiplier done.
- mult_product  in  16  multiplier result, valid while mult_done.
- mult_state  in  3  multiplier state_out.
- mult_rst_n  out  1  to multiplier reset_a (active-low).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RECOVER, RESP.
- IDLE:
  - If either valid is high, the arbiter grants one requester and drives its ready high.
  - Operands and id are latched; next state is ISSUE.
  - If both valid are high, the requester other than last_grant wins.
- ISSUE: mult_start=1 for exactly this cycle; timer cleared; next state is WAIT.
- WAIT: timer increments each cycle.
  - mult_state==ERR_CODE, or timer==TIMEOUT-1: set err=1, product=0, go to RECOVER.
  - Otherwise, mult_done=1: capture mult_product, err=0, go to RESP.
  - If error and done occur together, error wins.
- RECOVER: mult_rst_n=0 for one cycle; next state is RESP.
- RESP: rsp_valid=1 with registered rsp_id, rsp_product and rsp_err.
  - Fields hold until rsp_ready.
  - On the handshake: last_grant←rsp_id, go to IDLE.
- Requests arriving while busy see ready=0 and must hold valid.
- mult_done outside WAIT is ignored.
- Product is full 16-bit unsigned; 255×255=16'hFE01, no truncation.
- Timer width is clog2(TIMEOUT+1); the timer does not wrap within a WAIT.

## Timing
- Reset values: state IDLE, last_grant=1 (req0 wins first), rsp_* = 0, mult_start=0, mult_a=mult_b=0, busy=0.
- mult_rst_n is 0 while reset_a is high and 1 the cycle after release.
- Reset mid-operation: the operation is abandoned, no response is produced, and the multiplier is reset.
- Accept in cycle T (ready high); mult_start high in T+1.
- If mult_done is high in cycle T+1+N, rsp_valid is first high in T+2+N.
- Nominal multiplier (N=5): rsp_valid in T+7.
- Timeout path: rsp_valid in T+2+TIMEOUT+1, which includes the RECOVER cycle.
- If rsp_ready is high when rsp_valid rises, the next acceptance is possible in T+3+N.
- No back-to-back overlap: one operation in flight.

## Structure
- Shared package mult_pkg holds:
  - operand width 8 and product width 16;
  - multiplier state encodings (idle 000, lsb 001, mid 010, msb 011, calc_done 100, err 101);
  - the scheduler state enum.
- One natural sub-module: rr_arb2.
  - 2-way round-robin grant from the two valid bits and last_grant.
  - Purely combinational, one-hot grant output.
- The top level holds the FSM, timer, operand/response registers and multiplier drive.

## Test plan
- Single request: req0 with a=8'd12, b=8'd13 in IDLE → req0_ready in T, mult_start in T+1 only, rsp_valid in T+7 with id=0, product=16'd156, err=0.
- Contention: both valid after reset → req0 served first. Hold both valid → next grant req1, then req0 (alternation). Operands 255×255 → 16'hFE01.
- Backpressure: rsp_ready low for 5 cycles → rsp_* stable, req ready stays 0, busy=1. Release → IDLE next cycle.
- Error: mult_state forced to 3'b101 in WAIT → RECOVER with mult_rst_n=0 for one cycle, then rsp_err=1, rsp_product=0.
- Timeout: mult_done never asserted, TIMEOUT=16 → rsp_valid with err=1 in T+19; the multiplier is reset exactly once.
- Reset mid-WAIT: reset_a high for one cycle → no rsp_valid. Outputs at reset values, mult_rst_n low during reset, a new request accepted after release.
